mem_port_arbiter: RTL and testbench

Shares the single instruction/data memory port between the fetch stage (IF port) and the load/store unit (LS port). It runs one transaction at a time over the memory handshake (`mem_req` / `mem_ready` / `valid`). It arbitrates with LS priority and a starvation limit for IF, and enforces a response timeout. It sits between the fetch/LSU datapaths and the memory model or wrapper.

---
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/LS shared memory port arbiter with starvation limit and response timeout
module mem_port_arbiter #(
  parameter int bits       = 32,
  parameter int STARVE_LIM = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            if_req,
  input  logic [bits-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_valid,
  output logic [bits-1:0] if_rdata,
  output logic            if_err,
  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [bits-1:0] ls_addr,
  input  logic [bits-1:0] ls_wdata,
  output logic            ls_gnt,
  output logic            ls_valid,
  output logic [bits-1:0] ls_rdata,
  output logic            ls_err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [bits-1:0] mem_addr,
  output logic [bits-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic            valid,
  input  logic [bits-1:0] Rdata
);

  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t          r_state;
  logic            r_owner_ls;
  logic [SW-1:0]   r_starve_cnt;
  logic [TW-1:0]   r_timer;
  logic            r_mem_req;
  logic            r_mem_we;
  logic [bits-1:0] r_mem_addr;
  logic [bits-1:0] r_mem_wdata;
  logic            r_if_valid;
  logic            r_if_err;
  logic [bits-1:0] r_if_rdata;
  logic            r_ls_valid;
  logic            r_ls_err;
  logic [bits-1:0] r_ls_rdata;

  logic            w_if_starved;
  logic            w_ls_win;
  logic            w_if_win;
  logic            w_if_gnt;
  logic            w_ls_gnt;
  logic            w_done;
  logic            w_timeout;
  logic [bits-1:0] w_cap_data;

  // Arbitration and response detection; grants only leave IDLE while out of reset
  always_comb begin
    w_if_starved = (r_starve_cnt == SW'(STARVE_LIM)) && if_req;
    w_ls_win     = ls_req && !w_if_starved;
    w_if_win     = if_req && !w_ls_win;
    w_if_gnt     = reset_n && (r_state == S_IDLE) && w_if_win;
    w_ls_gnt     = reset_n && (r_state == S_IDLE) && w_ls_win;
    w_timeout    = (r_state == S_WAIT) && !valid && (r_timer == TW'(TIMEOUT - 1));
    w_done       = ((r_state == S_REQ) && mem_ready && valid) ||
                   ((r_state == S_WAIT) && (valid || w_timeout));
    w_cap_data   = (w_timeout || r_mem_we) ? '0 : Rdata;
  end

  // Transaction FSM with registered memory-side and response outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_owner_ls   <= 1'b0;
      r_starve_cnt <= '0;
      r_timer      <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_if_valid   <= 1'b0;
      r_if_err     <= 1'b0;
      r_if_rdata   <= '0;
      r_ls_valid   <= 1'b0;
      r_ls_err     <= 1'b0;
      r_ls_rdata   <= '0;
    end else begin
      r_if_valid <= 1'b0;
      r_if_err   <= 1'b0;
      r_ls_valid <= 1'b0;
      r_ls_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_if_gnt || w_ls_gnt) begin
            r_owner_ls  <= w_ls_gnt;
            r_mem_req   <= 1'b1;
            r_mem_we    <= w_ls_gnt && ls_we;
            r_mem_addr  <= w_ls_gnt ? ls_addr : if_addr;
            r_mem_wdata <= w_ls_gnt ? ls_wdata : '0;
            r_state     <= S_REQ;
            // IF waiting behind an LS grant accumulates starvation credit
            if (w_if_gnt || !if_req) begin
              r_starve_cnt <= '0;
            end else if (r_starve_cnt != SW'(STARVE_LIM)) begin
              r_starve_cnt <= r_starve_cnt + SW'(1);
            end
          end
        end
        S_REQ: begin
          if (mem_ready) begin
            r_mem_req <= 1'b0;
            r_timer   <= '0;
            r_state   <= valid ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          r_timer <= r_timer + TW'(1);
          if (w_done) begin
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
      // Response pulse is raised on the edge that enters RESP
      if (w_done) begin
        if (r_owner_ls) begin
          r_ls_valid <= 1'b1;
          r_ls_err   <= w_timeout;
          r_ls_rdata <= w_cap_data;
        end else begin
          r_if_valid <= 1'b1;
          r_if_err   <= w_timeout;
          r_if_rdata <= w_cap_data;
        end
      end
    end
  end

  assign if_gnt    = w_if_gnt;
  assign ls_gnt    = w_ls_gnt;
  assign if_valid  = r_if_valid;
  assign if_err    = r_if_err;
  assign if_rdata  = r_if_rdata;
  assign ls_valid  = r_ls_valid;
  assign ls_err    = r_ls_err;
  assign ls_rdata  = r_ls_rdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_gnt;
  logic        ls_valid;
  logic [31:0] ls_rdata;
  logic        ls_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        valid;
  logic [31:0] Rdata;

  int n_cmp;
  int n_bad;

  mem_port_arbiter #(.bits(32), .STARVE_LIM(4), .TIMEOUT(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_valid(if_valid), .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_valid(ls_valid), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .valid(valid), .Rdata(Rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [31:0] b2b_addr [3];
  logic [31:0] b2b_data [3];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset_n = 1'b0; if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0;
    ls_addr = '0; ls_wdata = '0; mem_ready = 1'b0; valid = 1'b0; Rdata = '0;
    b2b_addr[0] = 32'h0000_1000; b2b_data[0] = 32'h1111_0001;
    b2b_addr[1] = 32'h0000_1004; b2b_data[1] = 32'h2222_0002;
    b2b_addr[2] = 32'h0000_1008; b2b_data[2] = 32'h3333_0003;

    // reset state
    step(); step();
    check_val("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check_val("rst_mem_addr", mem_addr, 32'd0);
    check_val("rst_valids", {30'b0, if_valid, ls_valid}, 32'd0);
    check_val("rst_gnts", {30'b0, if_gnt, ls_gnt}, 32'd0);
    reset_n = 1'b1;
    step();

    // single fetch, minimum latency
    if_req = 1'b1; if_addr = 32'h100; mem_ready = 1'b1; valid = 1'b1; Rdata = 32'hDEADBEEF;
    settle();
    check_val("sf_if_gnt", {31'b0, if_gnt}, 32'd1);
    check_val("sf_ls_gnt", {31'b0, ls_gnt}, 32'd0);
    step();
    if_req = 1'b0;
    check_val("sf_mem_req", {31'b0, mem_req}, 32'd1);
    check_val("sf_mem_addr", mem_addr, 32'h100);
    check_val("sf_mem_we", {31'b0, mem_we}, 32'd0);
    step();
    mem_ready = 1'b0; valid = 1'b0;
    check_val("sf_if_valid", {31'b0, if_valid}, 32'd1);
    check_val("sf_if_rdata", if_rdata, 32'hDEADBEEF);
    check_val("sf_if_err", {31'b0, if_err}, 32'd0);
    check_val("sf_ls_valid", {31'b0, ls_valid}, 32'd0);
    check_val("sf_mem_req_off", {31'b0, mem_req}, 32'd0);
    step();
    check_val("sf_pulse_one", {31'b0, if_valid}, 32'd0);
    check_val("sf_rdata_hold", if_rdata, 32'hDEADBEEF);

    // back-to-back fetches, grants every third cycle
    if_req = 1'b1; if_addr = b2b_addr[0]; mem_ready = 1'b1; valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      check_val("b2b_gnt", {31'b0, if_gnt}, 32'd1);
      step();
      if (k < 2) if_addr = b2b_addr[k+1]; else if_req = 1'b0;
      Rdata = b2b_data[k];
      settle();
      check_val("b2b_addr", mem_addr, b2b_addr[k]);
      check_val("b2b_gnt_req", {31'b0, if_gnt}, 32'd0);
      step();
      check_val("b2b_valid", {31'b0, if_valid}, 32'd1);
      check_val("b2b_rdata", if_rdata, b2b_data[k]);
      check_val("b2b_gnt_resp", {31'b0, if_gnt}, 32'd0);
      step();
    end
    mem_ready = 1'b0; valid = 1'b0;

    // LS write, mem_ready 3 cycles late, valid 2 cycles later
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h20; ls_wdata = 32'h55;
    settle();
    check_val("wr_ls_gnt", {31'b0, ls_gnt}, 32'd1);
    step();
    ls_req = 1'b0; ls_addr = 32'h99; ls_wdata = 32'h77;
    for (int i = 0; i < 3; i++) begin
      check_val("wr_mem_req", {31'b0, mem_req}, 32'd1);
      check_val("wr_mem_we", {31'b0, mem_we}, 32'd1);
      check_val("wr_mem_addr", mem_addr, 32'h20);
      check_val("wr_mem_wdata", mem_wdata, 32'h55);
      step();
    end
    mem_ready = 1'b1; Rdata = 32'hABCD;
    step();
    mem_ready = 1'b0;
    check_val("wr_wait_req", {31'b0, mem_req}, 32'd0);
    check_val("wr_wait_valid", {31'b0, ls_valid}, 32'd0);
    step();
    valid = 1'b1; Rdata = 32'h1234;
    check_val("wr_early_valid", {31'b0, ls_valid}, 32'd0);
    step();
    valid = 1'b0;
    check_val("wr_ls_valid", {31'b0, ls_valid}, 32'd1);
    check_val("wr_ls_rdata", ls_rdata, 32'd0);
    check_val("wr_ls_err", {31'b0, ls_err}, 32'd0);
    check_val("wr_if_valid", {31'b0, if_valid}, 32'd0);
    step();
    check_val("wr_single", {31'b0, ls_valid}, 32'd0);
    ls_we = 1'b0;

    // starvation: both held, expected LS,LS,LS,LS,IF,LS
    if_req = 1'b1; if_addr = 32'h400; ls_req = 1'b1; ls_addr = 32'h44;
    mem_ready = 1'b1; valid = 1'b1; Rdata = 32'h5;
    for (int g = 0; g < 6; g++) begin
      settle();
      check_val("stv_ls_gnt", {31'b0, ls_gnt}, (g == 4) ? 32'd0 : 32'd1);
      check_val("stv_if_gnt", {31'b0, if_gnt}, (g == 4) ? 32'd1 : 32'd0);
      step();
      step();
      check_val("stv_ls_valid", {31'b0, ls_valid}, (g == 4) ? 32'd0 : 32'd1);
      check_val("stv_if_valid", {31'b0, if_valid}, (g == 4) ? 32'd1 : 32'd0);
      step();
    end
    if_req = 1'b0; ls_req = 1'b0; mem_ready = 1'b0; valid = 1'b0;
    step();

    // timeout: accepted, never answered
    if_req = 1'b1; if_addr = 32'h300;
    settle();
    check_val("to_gnt", {31'b0, if_gnt}, 32'd1);
    step();
    if_req = 1'b0; mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin
      check_val("to_no_pulse", {31'b0, if_valid}, 32'd0);
      step();
    end
    check_val("to_valid", {31'b0, if_valid}, 32'd1);
    check_val("to_err", {31'b0, if_err}, 32'd1);
    check_val("to_rdata", if_rdata, 32'd0);
    step();
    valid = 1'b1; Rdata = 32'hBAD0BAD0;
    step();
    check_val("to_stray_if", {31'b0, if_valid}, 32'd0);
    check_val("to_stray_ls", {31'b0, ls_valid}, 32'd0);
    step();
    check_val("to_stray_if2", {31'b0, if_valid}, 32'd0);
    valid = 1'b0;
    step();

    // valid on the last WAIT cycle beats the timeout
    ls_req = 1'b1; ls_addr = 32'h40;
    settle();
    check_val("lv_gnt", {31'b0, ls_gnt}, 32'd1);
    step();
    ls_req = 1'b0; mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    for (int i = 0; i < 63; i++) step();
    valid = 1'b1; Rdata = 32'hCAFE0001;
    check_val("lv_no_early", {31'b0, ls_valid}, 32'd0);
    step();
    valid = 1'b0;
    check_val("lv_valid", {31'b0, ls_valid}, 32'd1);
    check_val("lv_err", {31'b0, ls_err}, 32'd0);
    check_val("lv_rdata", ls_rdata, 32'hCAFE0001);
    step();

    // reset during WAIT
    if_req = 1'b1; if_addr = 32'h500;
    settle();
    check_val("rw_gnt", {31'b0, if_gnt}, 32'd1);
    step();
    if_req = 1'b0; mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check_val("rw_mem_req", {31'b0, mem_req}, 32'd0);
    check_val("rw_mem_addr", mem_addr, 32'd0);
    check_val("rw_valids", {30'b0, if_valid, ls_valid}, 32'd0);
    check_val("rw_rdata", if_rdata, 32'd0);
    valid = 1'b1; Rdata = 32'h0BAD0001;
    step();
    check_val("rw_stale1", {31'b0, if_valid}, 32'd0);
    step();
    check_val("rw_stale2", {31'b0, if_valid}, 32'd0);
    valid = 1'b0;
    if_req = 1'b1; if_addr = 32'h600; mem_ready = 1'b1; valid = 1'b1; Rdata = 32'h0060_0600;
    settle();
    check_val("rw_new_gnt", {31'b0, if_gnt}, 32'd1);
    step();
    if_req = 1'b0;
    check_val("rw_new_addr", mem_addr, 32'h600);
    step();
    mem_ready = 1'b0; valid = 1'b0;
    check_val("rw_new_valid", {31'b0, if_valid}, 32'd1);
    check_val("rw_new_rdata", if_rdata, 32'h0060_0600);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
